mux_scan_sel: RTL
=================

# mux_scan_sel

Parametrised, registered N-channel multiplexer with manual select and automatic round-robin scan modes; the successor to the 7-to-1 combinational selector. Each channel is held on the output for a programmable dwell count in scan mode. The block sits between multiple sensor/data sources and a single downstream consumer, and reports the active channel, wrap events and illegal selects.

## Interface

- WIDTH, 2: data width per channel, ≥1.
- CHANNELS, 7: number of input channels, 2..256.
- DWELL, 4: cycles each channel is held in scan mode, ≥1.
- SELW (localparam): max(1, $clog2(CHANNELS)).
- clk  in  1  rising-edge clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- in_bus  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- enable  in  1  1 = operate; 0 = freeze all state and outputs.
- mode  in  1  0 = MANUAL (sel_in drives selection), 1 = SCAN (internal round-robin).
- sel_in  in  SELW  manual channel select.
- z  out  WIDTH  registered selected channel data.
- sel_out  out  SELW  channel currently presented on z.
- valid  out  1  z holds legal channel data.
- wrap  out  1  one-cycle pulse when scan advances from CHANNELS-1 to 0.
- err  out  1  registered flag: manual sel_in ≥ CHANNELS.

## Operation

- States: IDLE (after reset, until first enabled cycle), MANUAL, SCAN. The next state is chosen from mode on every enabled cycle.
- Reset values: z=0, sel_out=0, valid=0, wrap=0, err=0, dwell counter=0, state=IDLE.
- MANUAL, sel_in < CHANNELS: sel_out←sel_in, z←in_bus[sel_in], valid←1, err←0.
- MANUAL, sel_in ≥ CHANNELS: z←0, valid←0, err←1. sel_out holds its previous value.
- SCAN: z←in_bus[sel_out channel] every enabled cycle, so data changes on the input are tracked. valid←1 and err←0.
- Dwell counter counts 0..DWELL-1. At DWELL-1 it clears and the channel advances by 1.
- Channel wrap: from CHANNELS-1 the channel advances to 0, with wrap=1 for that cycle only. Arithmetic is modulo CHANNELS, not modulo 2^SELW; the channel never exceeds CHANNELS-1.
- Entry into SCAN from MANUAL or IDLE starts at the current sel_out with the dwell counter cleared. No wrap is generated on entry.
- Entry into MANUAL from SCAN takes effect immediately. The dwell counter clears and any pending wrap is suppressed.
- enable=0: all registers hold, including the dwell counter, and wrap is forced to 0. Resuming continues the dwell count where it stopped.
- rst mid-scan: all state returns to reset values on that edge. This takes priority over enable and mode.
- DWELL=1: the channel advances every enabled cycle.

## Timing

- Latency: 1 cycle. Inputs sampled at edge N appear on z/sel_out/valid/err after edge N.
- z, sel_out, valid, wrap and err are all registered, with no combinational path from inputs to outputs.
- SCAN with DWELL=D: each channel is presented for exactly D consecutive enabled cycles. A full rotation takes CHANNELS*D enabled cycles.
- wrap asserts in the same cycle that sel_out first shows 0 after CHANNELS-1.
- First cycle after rst deasserts with enable=1: outputs update per mode at that edge. valid can be 1 one edge after reset release.

## Test plan

- Reset: hold rst=1 for 3 cycles with random in_bus -> z=0, sel_out=0, valid=0, wrap=0, err=0 at every edge.
- Manual sweep: WIDTH=2, CHANNELS=7, in_bus channels={00,01,11,11,10,01,10}, sel_in 0..6, one per cycle -> z one cycle later = 00,01,11,11,10,01,10; valid=1, err=0.
- Illegal select: sel_in=7 -> next cycle z=00, valid=0, err=1, sel_out unchanged. Then sel_in=2 -> z=11, err=0.
- Scan with DWELL=4, enable=1, mode=1 for 28 cycles -> each channel 0..6 is held exactly 4 cycles. wrap=1 exactly once, on the cycle sel_out returns to 0.
- Freeze: drop enable for 5 cycles mid-dwell on channel 3 (count=2) -> outputs frozen. After re-enable, channel 3 lasts 2 more cycles, then sel_out=4.
- Mode/reset mid-operation: switch to MANUAL with sel_in=5 while scanning channel 6 at count 3 -> next cycle sel_out=5 and no wrap. Return to SCAN -> starts at 5 for a full 4 cycles. Assert rst during SCAN -> reset values on the next edge.

Source files
------------

// File: rtl/mux_scan_sel.sv
// Registered N-channel multiplexer with a manual select mode and a round-robin scan mode.
// In scan mode each channel is held for DWELL enabled cycles before advancing. A one-cycle
// wrap pulse marks the return from the last channel to channel 0. An illegal manual select
// raises err and blanks the data.
module mux_scan_sel #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 7,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SELW    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned CW      = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  output logic [WIDTH-1:0]          z,
  output logic [SELW-1:0]           sel_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);

  localparam logic [SELW-1:0] LastCh    = SELW'(CHANNELS - 1);
  localparam logic [CW-1:0]   LastDwell = CW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

  state_e          state;
  logic [CW-1:0]   dwell_cnt;

  logic            in_scan;
  logic            dwell_last;
  logic            sel_legal;
  logic [SELW-1:0] scan_sel;
  logic            scan_wrap;
  logic [WIDTH-1:0] manual_data;
  logic [WIDTH-1:0] scan_data;
  logic [WIDTH-1:0] hold_data;

  // Loop-based lookup so that an out-of-range select never indexes past the bus.
  function automatic logic [WIDTH-1:0] chan_data(input logic [CHANNELS*WIDTH-1:0] bus,
                                                 input logic [SELW-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s == SELW'(k)) r = bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Next scan channel (modulo CHANNELS), wrap detection and channel data lookups.
  always_comb begin
    in_scan    = (state == StScan);
    dwell_last = (dwell_cnt == LastDwell);
    sel_legal  = ({{(32 - SELW){1'b0}}, sel_in} < CHANNELS);
    scan_sel   = sel_out;
    scan_wrap  = 1'b0;
    if (in_scan && dwell_last) begin
      if (sel_out == LastCh) begin
        scan_sel  = '0;
        scan_wrap = 1'b1;
      end else begin
        scan_sel  = sel_out + SELW'(1);
      end
    end
    manual_data = chan_data(in_bus, sel_in);
    scan_data   = chan_data(in_bus, scan_sel);
    hold_data   = chan_data(in_bus, sel_out);
  end

  // Mode FSM with all outputs registered; reset beats enable, enable beats mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      dwell_cnt <= '0;
      z         <= '0;
      sel_out   <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else if (!enable) begin
      // Freeze everything; wrap is a pulse, so it must not stretch across a stall.
      wrap <= 1'b0;
    end else if (mode) begin
      state <= StScan;
      valid <= 1'b1;
      err   <= 1'b0;
      if (in_scan) begin
        sel_out   <= scan_sel;
        dwell_cnt <= dwell_last ? '0 : dwell_cnt + CW'(1);
        wrap      <= scan_wrap;
        z         <= scan_data;
      end else begin
        // Scan entry: start on the current channel with a fresh dwell, no wrap.
        dwell_cnt <= '0;
        wrap      <= 1'b0;
        z         <= hold_data;
      end
    end else begin
      state     <= StManual;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
      if (sel_legal) begin
        sel_out <= sel_in;
        z       <= manual_data;
        valid   <= 1'b1;
        err     <= 1'b0;
      end else begin
        z       <= '0;
        valid   <= 1'b0;
        err     <= 1'b1;
      end
    end
  end

endmodule
